// File: rtl/bad_packet_filter_pkg.sv
// Shared types, widths and helpers for the store-and-forward bad-packet filter.
package bad_packet_filter_pkg;

  localparam int unsigned COUNT_W = 32;

  typedef enum logic {
    IDLE_OR_ACTIVE,
    POISONED
  } pkt_state_e;

  // One extra bit beyond the address so full and empty are distinguishable.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bad_packet_filter_ram.sv
// Simple dual-port packet buffer: one write port, one read port with registered output.
module bad_packet_filter_ram
  import bad_packet_filter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/bad_packet_filter.sv
// Store-and-forward filter dropping TUSER-flagged and overflowing packets.
// Packet counters are built only when BAD_PACKET_FILTER_STATS_EN is defined.
module bad_packet_filter
  import bad_packet_filter_pkg::*;
#(
  parameter int unsigned DATA_WBITS = 512,
  parameter int unsigned DATA_WBYTS = DATA_WBITS / 8,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WBITS-1:0] AXIS_IN_TDATA,
  input  logic [DATA_WBYTS-1:0] AXIS_IN_TKEEP,
  input  logic                  AXIS_IN_TUSER,
  input  logic                  AXIS_IN_TLAST,
  input  logic                  AXIS_IN_TVALID,
  output logic                  AXIS_IN_TREADY,
  output logic [DATA_WBITS-1:0] AXIS_OUT_TDATA,
  output logic [DATA_WBYTS-1:0] AXIS_OUT_TKEEP,
  output logic                  AXIS_OUT_TLAST,
  output logic                  AXIS_OUT_TVALID,
  input  logic                  AXIS_OUT_TREADY,
  output logic                  overrun,
  output logic [COUNT_W-1:0]    good_count,
  output logic [COUNT_W-1:0]    bad_count,
  output logic [COUNT_W-1:0]    ovfl_count
);

  localparam int unsigned PtrW = ptr_w(DEPTH);
  localparam int unsigned AddrW = PtrW - 1;
  localparam int unsigned MemW = DATA_WBITS + DATA_WBYTS + 1;
  localparam logic [PtrW-1:0] DepthVal = PtrW'(DEPTH);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  logic [PtrW-1:0] wr_q, wr_d, commit_q, commit_d, rd_q, rd_d;
  pkt_state_e      state_q, state_d;
  logic            overrun_q, overrun_d;
  logic            in_acc, full, wr_en, good_inc, bad_inc, ovfl_inc;

  assign AXIS_IN_TREADY = ~reset;
  assign in_acc         = AXIS_IN_TVALID & AXIS_IN_TREADY;
  assign full           = (wr_q - rd_q) == DepthVal;
  assign overrun        = overrun_q;

  always_comb begin
    wr_d      = wr_q;
    commit_d  = commit_q;
    state_d   = state_q;
    overrun_d = 1'b0;
    wr_en     = 1'b0;
    good_inc  = 1'b0;
    bad_inc   = 1'b0;
    ovfl_inc  = 1'b0;
    if (in_acc) begin
      if (state_q == POISONED || full) begin
        overrun_d = 1'b1;
        if (AXIS_IN_TLAST) begin
          wr_d     = commit_q;
          state_d  = IDLE_OR_ACTIVE;
          ovfl_inc = 1'b1;
        end else begin
          state_d = POISONED;
        end
      end else if (AXIS_IN_TLAST && AXIS_IN_TUSER) begin
        wr_d    = commit_q;
        bad_inc = 1'b1;
      end else begin
        wr_en = 1'b1;
        wr_d  = wr_q + PtrOne;
        if (AXIS_IN_TLAST) begin
          commit_d = wr_q + PtrOne;
          good_inc = 1'b1;
        end
      end
    end
  end

  // Read side: RAM read register feeds a 2-entry FWFT buffer; a read is issued only
  // when the buffer is guaranteed a free slot when the data lands.
  logic [1:0]      ob_cnt_q, ob_cnt_after;
  logic            ob_wr_q, ob_rd_q, rd_vld_q, rd_en, pop;
  logic [MemW-1:0] ob_mem_q [2];
  logic [MemW-1:0] ram_rdata;

  assign pop          = AXIS_OUT_TVALID & AXIS_OUT_TREADY;
  assign ob_cnt_after = ob_cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};
  assign rd_en        = (rd_q != commit_q) && (ob_cnt_after < 2'd2);
  assign rd_d         = rd_en ? rd_q + PtrOne : rd_q;

  assign AXIS_OUT_TVALID = ob_cnt_q != 2'd0;
  assign {AXIS_OUT_TLAST, AXIS_OUT_TKEEP, AXIS_OUT_TDATA} = ob_mem_q[ob_rd_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q      <= '0;
      commit_q  <= '0;
      rd_q      <= '0;
      state_q   <= IDLE_OR_ACTIVE;
      overrun_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      ob_cnt_q  <= 2'd0;
      ob_wr_q   <= 1'b0;
      ob_rd_q   <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      commit_q  <= commit_d;
      rd_q      <= rd_d;
      state_q   <= state_d;
      overrun_q <= overrun_d;
      rd_vld_q  <= rd_en;
      ob_cnt_q  <= ob_cnt_after;
      if (rd_vld_q) begin
        ob_mem_q[ob_wr_q] <= ram_rdata;
        ob_wr_q           <= ~ob_wr_q;
      end
      if (pop) ob_rd_q <= ~ob_rd_q;
    end
  end

  bad_packet_filter_ram #(
    .WIDTH(MemW),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk_i    (clk),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_q[AddrW-1:0]),
    .wr_data_i({AXIS_IN_TLAST, AXIS_IN_TKEEP, AXIS_IN_TDATA}),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_q[AddrW-1:0]),
    .rd_data_o(ram_rdata)
  );

`ifdef BAD_PACKET_FILTER_STATS_EN
  logic [COUNT_W-1:0] good_q, bad_q, ovfl_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      good_q <= '0;
      bad_q  <= '0;
      ovfl_q <= '0;
    end else begin
      if (good_inc && good_q != '1) good_q <= good_q + COUNT_W'(1);
      if (bad_inc && bad_q != '1) bad_q <= bad_q + COUNT_W'(1);
      if (ovfl_inc && ovfl_q != '1) ovfl_q <= ovfl_q + COUNT_W'(1);
    end
  end

  assign good_count = good_q;
  assign bad_count  = bad_q;
  assign ovfl_count = ovfl_q;
`else
  logic unused_stats;
  assign unused_stats = good_inc ^ bad_inc ^ ovfl_inc;
  assign good_count   = '0;
  assign bad_count    = '0;
  assign ovfl_count   = '0;
`endif

endmodule

// File: tb/tb_bad_packet_filter.sv
// Scoreboard bench for bad_packet_filter (DEPTH=16, 64-bit data).
module tb_bad_packet_filter;
  import bad_packet_filter_pkg::*;

  localparam int unsigned DW = 64;
  localparam int unsigned DB = 8;
  localparam int unsigned DEPTH = 16;
`ifdef BAD_PACKET_FILTER_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  typedef struct packed {
    logic          last;
    logic [DB-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic [DB-1:0] in_keep = '0;
  logic in_user = 1'b0, in_last = 1'b0, in_valid = 1'b0, in_ready;
  logic [DW-1:0] out_data;
  logic [DB-1:0] out_keep;
  logic out_last, out_valid;
  logic out_ready = 1'b0;
  logic overrun;
  logic [COUNT_W-1:0] good_count, bad_count, ovfl_count;

  int checks = 0;
  int passes = 0;
  int exp_good = 0, exp_bad = 0, exp_ovfl = 0;
  beat_t sb[$];
  bit hold_v = 1'b0;
  beat_t hold_b;

  always #5 clk = ~clk;

  bad_packet_filter #(
    .DATA_WBITS(DW),
    .DATA_WBYTS(DB),
    .DEPTH     (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .AXIS_IN_TDATA  (in_data),
    .AXIS_IN_TKEEP  (in_keep),
    .AXIS_IN_TUSER  (in_user),
    .AXIS_IN_TLAST  (in_last),
    .AXIS_IN_TVALID (in_valid),
    .AXIS_IN_TREADY (in_ready),
    .AXIS_OUT_TDATA (out_data),
    .AXIS_OUT_TKEEP (out_keep),
    .AXIS_OUT_TLAST (out_last),
    .AXIS_OUT_TVALID(out_valid),
    .AXIS_OUT_TREADY(out_ready),
    .overrun        (overrun),
    .good_count     (good_count),
    .bad_count      (bad_count),
    .ovfl_count     (ovfl_count)
  );

  // Output monitor: pops the scoreboard on every handshake, checks stall stability.
  always @(negedge clk) begin
    beat_t got;
    beat_t exp;
    got = {out_last, out_keep, out_data};
    if (!reset && out_valid === 1'b1) begin
      if (hold_v) begin
        checks++;
        if (got !== hold_b) $display("FAIL stall_stable: got %h required %h", got, hold_b);
        else passes++;
      end
      if (out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_beat: got %h required no beat", got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) $display("FAIL out_beat: got %h required %h", got, exp);
          else passes++;
        end
        hold_v = 1'b0;
      end else begin
        hold_v = 1'b1;
        hold_b = got;
      end
    end else begin
      if (hold_v && !reset) begin
        checks++;
        $display("FAIL stall_valid_drop: got tvalid=%b required 1", out_valid);
      end
      hold_v = 1'b0;
    end
  end

  task automatic drive_beat(input logic [DW-1:0] d, input logic [DB-1:0] k, input logic l,
                            input logic u);
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    in_user  = u;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_user  = 1'b0;
  endtask

  task automatic send_pkt(input int len, input bit bad, input bit expect_out);
    logic [DW-1:0] d;
    logic [DB-1:0] k;
    for (int i = 0; i < len; i++) begin
      d = {$urandom, $urandom};
      k = (i == len - 1) ? DB'($urandom_range(1, 255)) : '1;
      if (expect_out) sb.push_back({(i == len - 1), k, d});
      drive_beat(d, k, (i == len - 1), bad && (i == len - 1));
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) $display("FAIL %s_drain: got %0d beats left required 0", name, sb.size());
    else passes++;
  endtask

  task automatic check_counters(input string name);
    checks++;
    if (good_count !== (StatsEn ? COUNT_W'(exp_good) : '0) ||
        bad_count !== (StatsEn ? COUNT_W'(exp_bad) : '0) ||
        ovfl_count !== (StatsEn ? COUNT_W'(exp_ovfl) : '0))
      $display("FAIL %s_counters: got %0d/%0d/%0d required %0d/%0d/%0d (stats=%0b)", name,
               good_count, bad_count, ovfl_count, exp_good, exp_bad, exp_ovfl, StatsEn);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || overrun !== 1'b0)
      $display("FAIL reset_outputs: got ready=%b valid=%b overrun=%b required 0/0/0",
               in_ready, out_valid, overrun);
    else passes++;
    check_counters("reset");
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", in_ready);
    else passes++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    fork
      begin
        repeat (3) send_pkt(4, 1'b0, 1'b1);
        idle_in();
      end
      begin
        int run = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL latency_e0: got %b required 0", out_valid);
        else passes++;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL latency_e1: got %b required 0", out_valid);
        else passes++;
        for (int i = 0; i < 12; i++) begin
          @(negedge clk);
          if (out_valid === 1'b1) run++;
        end
        checks++;
        if (run != 12) $display("FAIL b2b_continuous: got %0d valid cycles required 12", run);
        else passes++;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL b2b_end: got %b required 0", out_valid);
        else passes++;
      end
    join
    wait_drain("b2b");
    exp_good += 3;
    check_counters("b2b");
  endtask

  task automatic test_bad_packet();
    out_ready = 1'b1;
    send_pkt(4, 1'b0, 1'b1);
    send_pkt(4, 1'b1, 1'b0);
    send_pkt(4, 1'b0, 1'b1);
    idle_in();
    wait_drain("bad");
    exp_good += 2;
    exp_bad += 1;
    check_counters("bad");
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      drive_beat({$urandom, $urandom}, '1, (k == 20), 1'b0);
      checks++;
      if (overrun !== (k >= 17)) $display("FAIL overrun_beat%0d: got %b required %b", k, overrun, (k >= 17));
      else passes++;
    end
    idle_in();
    @(posedge clk);
    #1;
    checks++;
    if (overrun !== 1'b0) $display("FAIL overrun_clear: got %b required 0", overrun);
    else passes++;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL ovfl_no_output: got %b required 0", out_valid);
    else passes++;
    exp_ovfl += 1;
    check_counters("ovfl");
    send_pkt(4, 1'b0, 1'b1);
    idle_in();
    out_ready = 1'b1;
    wait_drain("after_ovfl");
    exp_good += 1;
    check_counters("after_ovfl");
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    fork
      begin
        send_pkt(DEPTH, 1'b0, 1'b1);
        idle_in();
      end
      begin
        repeat (40) begin
          out_ready = ~out_ready;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("stall");
    exp_good += 1;
    check_counters("stall");
  endtask

  task automatic test_reset_mid_packet();
    out_ready = 1'b0;
    send_pkt(4, 1'b0, 1'b0);
    idle_in();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) $display("FAIL pre_reset_valid: got %b required 1", out_valid);
    else passes++;
    drive_beat({$urandom, $urandom}, '1, 1'b0, 1'b0);
    in_data = {$urandom, $urandom};
    reset   = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL mid_reset_ready: got %b required 0", in_ready);
    else passes++;
    reset = 1'b0;
    idle_in();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b required 0", out_valid);
    else passes++;
    exp_good = 0;
    exp_bad  = 0;
    exp_ovfl = 0;
    check_counters("mid_reset");
    sb.delete();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_pkt(4, 1'b0, 1'b1);
    idle_in();
    wait_drain("post_reset");
    exp_good = 1;
    check_counters("post_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_bad_packet();
    test_overflow();
    test_stall();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
